// File: rtl/lc3_display_tx.sv
// lc3_display_tx: LC-3 display device (DSR/DDR) serializing DDR writes onto an 8N1 UART line.
// Optional interrupt enable (DSR[14]) and irq output are built when LC3_DSP_IRQ_EN is defined.
module lc3_display_tx #(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [15:0] DSR_ADDR     = 16'hFE04,
  parameter logic [15:0] DDR_ADDR     = 16'hFE06
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        tx,
  output logic        irq
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d, shadow_q, shadow_d;
  logic          tx_q, tx_d;
  logic [15:0]   rdata_q, rdata_d, rd_val;
  logic          ready, ie, last, ddr_wr, unused_w;
  assign ready    = state_q == IDLE;
  assign last     = baud_q == BW'(CLKS_PER_BIT - 1);
  assign ddr_wr   = we && addr == DDR_ADDR;
  assign rd_val   = addr == DSR_ADDR ? {ready, ie, 14'b0} :
                    addr == DDR_ADDR ? {8'b0, shadow_q} : 16'h0000;
  assign unused_w = ^wdata[15:8];
  assign rdata    = rdata_q;
  assign tx       = tx_q;
  assign irq      = ready & ie;
`ifdef LC3_DSP_IRQ_EN
  logic ie_q;
  always_ff @(posedge clk or posedge clr)
    if (clr) ie_q <= 1'b0;
    else if (we && addr == DSR_ADDR) ie_q <= wdata[14];
  assign ie = ie_q;
`else
  assign ie = 1'b0;
`endif
  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    shadow_d = shadow_q;
    tx_d     = tx_q;
    baud_d   = (state_q == IDLE || last) ? '0 : baud_q + BW'(1);
    rdata_d  = re ? rd_val : rdata_q;
    case (state_q)
      IDLE: if (ddr_wr) begin
        shift_d  = wdata[7:0];
        shadow_d = wdata[7:0];
        tx_d     = 1'b0;
        state_d  = START;
      end
      START: if (last) begin
        state_d = DATA;
        bit_d   = 3'd0;
        tx_d    = shift_q[0];
        shift_d = shift_q >> 1;
      end
      DATA: if (last) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          bit_d   = bit_q + 3'd1;
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      STOP: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      shadow_q <= '0;
      tx_q     <= 1'b1;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      shadow_q <= shadow_d;
      tx_q     <= tx_d;
      rdata_q  <= rdata_d;
    end
endmodule

// File: tb/tb_lc3_display_tx.sv
// tb_lc3_display_tx: directed self-checking bench for lc3_display_tx with CLKS_PER_BIT=4.
module tb_lc3_display_tx;
  localparam logic [15:0] DSR = 16'hFE04;
  localparam logic [15:0] DDR = 16'hFE06;
  logic clk = 1'b0, clr = 1'b1, we = 1'b0, re = 1'b0, tx, irq;
  logic [15:0] addr = '0, wdata = '0, rdata, v;
  int checks = 0, errors = 0;
  lc3_display_tx #(.CLKS_PER_BIT(4), .DSR_ADDR(DSR), .DDR_ADDR(DDR)) dut (
    .clk(clk), .clr(clr), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .rdata(rdata), .tx(tx), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    addr = a; wdata = d; we = 1'b1;
    tick();
    we = 1'b0;
  endtask
  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    addr = a; re = 1'b1;
    tick();
    re = 1'b0;
    d = rdata;
  endtask
  // Called in cycle 0 of a frame; checks all 40 tx cycles, a busy DSR read,
  // a dropped mid-frame write and the DDR shadow; returns in the first ready cycle.
  task automatic frame(input logic [7:0] d, input logic [7:0] sh, input string nm);
    int idx;
    logic e;
    for (int k = 0; k < 40; k++) begin
      idx = k / 4;
      e = idx == 0 ? 1'b0 : idx == 9 ? 1'b1 : d[idx-1];
      chk($sformatf("%s_tx_c%0d", nm, k), {15'b0, tx}, {15'b0, e});
      if (k == 6)  chk({nm, "_dsr_busy"}, rdata, 16'h0000);
      if (k == 21) chk({nm, "_ddr_shadow"}, rdata, {8'h00, sh});
      if (k == 3)  chk({nm, "_irq_busy"}, {15'b0, irq}, 16'h0000);
      we = 1'b0; re = 1'b0;
      if (k == 5)  begin addr = DSR; re = 1'b1; end
      if (k == 10) begin addr = DDR; wdata = 16'h0055; we = 1'b1; end
      if (k == 20) begin addr = DDR; re = 1'b1; end
      tick();
    end
    we = 1'b0; re = 1'b0;
  endtask
  initial begin
    repeat (3) tick();
    chk("rst_tx", {15'b0, tx}, 16'h0001);
    chk("rst_irq", {15'b0, irq}, 16'h0000);
    chk("rst_rdata", rdata, 16'h0000);
    clr = 1'b0;
    tick();
    bus_read(DSR, v); chk("rst_dsr", v, 16'h8000);
    bus_read(DDR, v); chk("rst_ddr", v, 16'h0000);
    bus_write(DDR, 16'h1241);
    frame(8'h41, 8'h41, "fa");
    chk("gap_tx", {15'b0, tx}, 16'h0001);
    bus_write(DDR, 16'h00FF);
    frame(8'hFF, 8'hFF, "fb");
    bus_read(DSR, v); chk("done_dsr", v, 16'h8000);
    bus_read(DDR, v); chk("done_ddr", v, 16'h00FF);
    bus_write(DDR, 16'h0041);
    repeat (13) tick();
    chk("pre_clr_tx", {15'b0, tx}, 16'h0000);
    clr = 1'b1;
    #1;
    chk("clr_tx", {15'b0, tx}, 16'h0001);
    tick();
    clr = 1'b0;
    tick();
    bus_read(DSR, v); chk("clr_dsr", v, 16'h8000);
    bus_read(DDR, v); chk("clr_ddr", v, 16'h0000);
    bus_write(16'hFE08, 16'h00AA);
    chk("unmap_tx", {15'b0, tx}, 16'h0001);
    bus_read(16'hFE08, v); chk("unmap_rd", v, 16'h0000);
    bus_read(DDR, v); chk("unmap_ddr", v, 16'h0000);
    addr = DDR; wdata = 16'h00A5; we = 1'b1; re = 1'b1;
    tick();
    we = 1'b0; re = 1'b0;
    chk("wr_rd_pre", rdata, 16'h0000);
    frame(8'hA5, 8'hA5, "fc");
    tick();
    chk("hold_rdata", rdata, 16'h00A5);
    bus_write(DSR, 16'h4000);
`ifdef LC3_DSP_IRQ_EN
    chk("ie_irq", {15'b0, irq}, 16'h0001);
    bus_read(DSR, v); chk("ie_dsr", v, 16'hC000);
    bus_write(DDR, 16'h0033);
    for (int k = 0; k < 40; k++) begin
      if (k % 8 == 0) chk($sformatf("irq_busy_c%0d", k), {15'b0, irq}, 16'h0000);
      tick();
    end
    chk("irq_back", {15'b0, irq}, 16'h0001);
`else
    chk("noie_irq", {15'b0, irq}, 16'h0000);
    bus_read(DSR, v); chk("noie_dsr", v, 16'h8000);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
